pipe_hazard_ctrl: RTL

- Central pipeline sequencer for the 5-stage core. It owns the fetch, decode and execute flop enables, and generates hazStall and flushPipe for the execute stage and the surrounding pipe registers.
- Detects RAW hazards without forwarding, sequences the multi-cycle flush after a taken branch or jump, freezes the pipe on data-memory stalls, and parks the core on halt.
- A stall watchdog flags a pipe that is stuck.

---
 rtl/pipe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central pipeline sequencer for the 5-stage core. Owns the fetch, decode and
// execute flop enables and produces hazStall / flushPipe for the execute
// stage and the surrounding pipe registers.
//
// Responsibilities:
//   - RAW hazard detection without forwarding (EX, MEM and WB writers).
//   - Multi-cycle flush after a taken branch or jump.
//   - Full freeze while data memory is not ready.
//   - Parking the core on halt.
//   - Stall watchdog that flags a pipe stuck in hazStall.
//
// Parameters:
//   FLUSH_CYC   cycles flushPipe is held after a redirect (1..7)
//   STALL_MAX   consecutive hazStall cycles before err sets (2..255)
//
// Ports:
//   clk                 system clock, all state on rising edge
//   rst                 synchronous, active-low reset
//   idRdReg1/idRd1En    decode source register 1 and its read enable
//   idRdReg2/idRd2En    decode source register 2 and its read enable
//   exWriteReg/exRegWrt     destination / write enable of instr in execute
//   memWriteReg/memRegWrt   destination / write enable of instr in memory
//   wbWriteReg/wbRegWrt     destination / write enable of instr in writeback
//   doBranch, jump      registered taken-branch / jump from execute
//   iMemStall           instruction memory not ready
//   dMemStall           data memory not ready
//   halt                halt instruction reached writeback
//   pcEn                PC register load enable
//   ifIdEn              IF/ID register load enable
//   ifIdBubble          IF/ID loads NOP instead of fetched instr
//   idExBubble          ID/EX loads control zeros
//   hazStall            freezes EX/MEM enables in the execute stage
//   flushPipe           clears younger pipe stages
//   halted              core parked
//   err                 sticky watchdog error
//   state               debug: current FSM state (RUN=0 FLUSH=1 MEMWAIT=2 HALT=3)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYC = 2,
    parameter int STALL_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] idRdReg1,
    input  logic       idRd1En,
    input  logic [2:0] idRdReg2,
    input  logic       idRd2En,
    input  logic [2:0] exWriteReg,
    input  logic       exRegWrt,
    input  logic [2:0] memWriteReg,
    input  logic       memRegWrt,
    input  logic [2:0] wbWriteReg,
    input  logic       wbRegWrt,
    input  logic       doBranch,
    input  logic       jump,
    input  logic       iMemStall,
    input  logic       dMemStall,
    input  logic       halt,
    output logic       pcEn,
    output logic       ifIdEn,
    output logic       ifIdBubble,
    output logic       idExBubble,
    output logic       hazStall,
    output logic       flushPipe,
    output logic       halted,
    output logic       err,
    output logic [1:0] state
);

    localparam int              SCW          = $clog2(STALL_MAX + 1);
    localparam logic [2:0]      FLUSH_RELOAD = 3'(FLUSH_CYC - 1);
    localparam logic [SCW-1:0]  STALL_LIM    = SCW'(STALL_MAX);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_flush_cnt;
    logic [2:0]     w_flush_cnt_nxt;
    logic           r_pend_redir;
    logic           w_pend_redir_nxt;
    logic [SCW-1:0] r_stall_cnt;
    logic [SCW-1:0] w_stall_cnt_nxt;
    logic           r_err;

    logic w_hit1;
    logic w_hit2;
    logic w_raw;
    logic w_redirect;

    logic w_pc_en;
    logic w_ifid_en;
    logic w_ifid_bubble;
    logic w_idex_bubble;
    logic w_haz_stall;
    logic w_flush;

    // RAW detection: a disabled source never hits; register 0 is an ordinary
    // register here, so no zero-register exclusion.
    assign w_hit1 = idRd1En & ((exRegWrt  & (exWriteReg  == idRdReg1)) |
                               (memRegWrt & (memWriteReg == idRdReg1)) |
                               (wbRegWrt  & (wbWriteReg  == idRdReg1)));
    assign w_hit2 = idRd2En & ((exRegWrt  & (exWriteReg  == idRdReg2)) |
                               (memRegWrt & (memWriteReg == idRdReg2)) |
                               (wbRegWrt  & (wbWriteReg  == idRdReg2)));
    assign w_raw      = w_hit1 | w_hit2;
    assign w_redirect = doBranch | jump;

    // Next-state and unforced outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_cnt_nxt  = r_flush_cnt;
        w_pend_redir_nxt = r_pend_redir;
        w_pc_en          = 1'b0;
        w_ifid_en        = 1'b0;
        w_ifid_bubble    = 1'b0;
        w_idex_bubble    = 1'b0;
        w_haz_stall      = 1'b0;
        w_flush          = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    w_flush         = 1'b1;
                    w_idex_bubble   = 1'b1;
                    w_pc_en         = 1'b1;
                    w_ifid_en       = 1'b1;
                    w_ifid_bubble   = 1'b1;
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = FLUSH_RELOAD;
                end else if (dMemStall) begin
                    w_haz_stall = 1'b1;
                    w_state_nxt = ST_MEMWAIT;
                end else if (w_raw) begin
                    w_idex_bubble = 1'b1;
                    w_haz_stall   = 1'b1;
                end else if (iMemStall) begin
                    // Hold the PC but keep feeding bubbles into decode.
                    w_ifid_en     = 1'b1;
                    w_ifid_bubble = 1'b1;
                end else begin
                    w_pc_en   = 1'b1;
                    w_ifid_en = 1'b1;
                end
            end

            ST_FLUSH: begin
                w_flush       = 1'b1;
                w_idex_bubble = 1'b1;
                w_ifid_bubble = 1'b1;
                w_ifid_en     = 1'b1;
                w_pc_en       = ~iMemStall;
                // dMemStall is deliberately ignored while flushing.
                if (w_redirect) begin
                    w_flush_cnt_nxt = FLUSH_RELOAD;
                end else if (r_flush_cnt == 3'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end

            ST_MEMWAIT: begin
                w_haz_stall = 1'b1;
                if (!dMemStall) begin
                    if (r_pend_redir || w_redirect) begin
                        w_state_nxt      = ST_FLUSH;
                        w_flush_cnt_nxt  = FLUSH_RELOAD;
                        w_pend_redir_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (w_redirect) begin
                    // Remember the redirect until memory releases the pipe.
                    w_pend_redir_nxt = 1'b1;
                end
            end

            default: begin
                w_idex_bubble = 1'b1;
                w_haz_stall   = 1'b1;
            end
        endcase

        // Halt wins over everything; outputs of this cycle stay as above.
        if (halt) begin
            w_state_nxt = ST_HALT;
        end
    end

    // Watchdog: saturating run-length of hazStall, frozen while parked.
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (r_state != ST_HALT) begin
            if (w_haz_stall) begin
                if (r_stall_cnt != STALL_LIM) begin
                    w_stall_cnt_nxt = r_stall_cnt + 1'b1;
                end
            end else begin
                w_stall_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_RUN;
            r_flush_cnt  <= 3'd0;
            r_pend_redir <= 1'b0;
            r_stall_cnt  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
            r_pend_redir <= w_pend_redir_nxt;
            r_stall_cnt  <= w_stall_cnt_nxt;
            r_err        <= r_err | (w_stall_cnt_nxt == STALL_LIM);
        end
    end

    // While reset is asserted the pipe is held flushed and everything else
    // is quiet, independent of the registered state.
    assign pcEn       = rst & w_pc_en;
    assign ifIdEn     = rst & w_ifid_en;
    assign ifIdBubble = rst & w_ifid_bubble;
    assign idExBubble = rst & w_idex_bubble;
    assign hazStall   = rst & w_haz_stall;
    assign flushPipe  = ~rst | w_flush;
    assign halted     = rst & (r_state == ST_HALT);
    assign err        = rst & r_err;
    assign state      = rst ? r_state : 2'd0;

endmodule
